gemm_accum_buf: RTL

//  Output-side accumulation buffer directly downstream of the super systolic array.
//  - Captures one row of SUPER_SYS_COLS partial sums per cycle while the array's valid is high.
//  - The first K-tile pass overwrites each row; later passes add to it.
//  - After the last K-tile, drains rows to the writeback path over a valid/ready handshake.

---
 rtl/gemm_accum_buf_pkg.sv | 19 +
 rtl/gemm_accum_buf_acc_lane.sv | 49 ++++
 rtl/gemm_accum_buf.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/gemm_accum_buf_pkg.sv
// Shared constants and types for the GEMM output accumulation buffer.
// Optional build macro GEMM_ACC_SAT_EN selects saturating lane adds.
package gemm_accum_buf_pkg;

    localparam int SUPER_SYS_COLS = 16;
    localparam int P_BITWIDTH     = 24;
    localparam int ACC_WIDTH      = 32;
    localparam int ACC_DEPTH      = 32;
    localparam int TILE_CNT_W     = 8;

    typedef enum logic [1:0] {
        ACC_IDLE,
        ACC_ACCUM,
        ACC_DRAIN
    } acc_state_e;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/gemm_accum_buf_acc_lane.sv
// One accumulator lane: sign-extend a partial sum, then overwrite or add.
// GEMM_ACC_SAT_EN defined: adds clamp to the signed range and flag the clip.
module gemm_accum_buf_acc_lane
    import gemm_accum_buf_pkg::*;
#(
    parameter int P_BITWIDTH = gemm_accum_buf_pkg::P_BITWIDTH,
    parameter int ACC_WIDTH  = gemm_accum_buf_pkg::ACC_WIDTH
) (
    input  logic [P_BITWIDTH-1:0] psum,
    input  logic [ACC_WIDTH-1:0]  acc_old,
    input  logic                  overwrite,
    output logic [ACC_WIDTH-1:0]  acc_new,
    output logic                  clip
);

    logic signed [ACC_WIDTH-1:0] ext;

    always_comb begin
        ext = ACC_WIDTH'($signed(psum));
    end

`ifdef GEMM_ACC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0] wide;

    // One guard bit: the two top bits disagree exactly when the signed add overflowed.
    always_comb begin
        wide    = {acc_old[ACC_WIDTH-1], acc_old} + {ext[ACC_WIDTH-1], ext};
        acc_new = ext;
        clip    = 1'b0;
        if (!overwrite) begin
            if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
                clip    = 1'b1;
                acc_new = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_new = wide[ACC_WIDTH-1:0];
            end
        end
    end
`else
    always_comb begin
        acc_new = overwrite ? ext : acc_old + ext;
        clip    = 1'b0;
    end
`endif

endmodule

// File: rtl/gemm_accum_buf.sv
// Accumulates systolic-array rows over K-tile passes, then drains them to writeback.
// Build macro GEMM_ACC_SAT_EN: saturating lane adds that set err on clip (default wraps).
module gemm_accum_buf #(
    parameter int SUPER_SYS_COLS = gemm_accum_buf_pkg::SUPER_SYS_COLS,
    parameter int P_BITWIDTH     = gemm_accum_buf_pkg::P_BITWIDTH,
    parameter int ACC_WIDTH      = gemm_accum_buf_pkg::ACC_WIDTH,
    parameter int ACC_DEPTH      = gemm_accum_buf_pkg::ACC_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [$clog2(ACC_DEPTH+1)-1:0]       cfg_rows,
    input  logic [7:0]                           cfg_tiles,
    input  logic                                 in_valid,
    input  logic                                 in_accum_start,
    input  logic [SUPER_SYS_COLS*P_BITWIDTH-1:0] in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SUPER_SYS_COLS*ACC_WIDTH-1:0]  out_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    import gemm_accum_buf_pkg::*;

    localparam int RW    = $clog2(ACC_DEPTH + 1);
    localparam int PW    = $clog2(ACC_DEPTH);
    localparam int ROW_W = SUPER_SYS_COLS * ACC_WIDTH;

    acc_state_e          state_q, state_d;
    logic [RW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [RW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [RW-1:0]       rows_q, rows_d;
    logic [7:0]          tile_cnt_q, tile_cnt_d;
    logic [7:0]          tiles_q, tiles_d;
    logic                err_q, err_d;
    logic                done_q, done_d;

    logic [ROW_W-1:0]    mem_q [ACC_DEPTH];
    logic                wr_en;
    logic [PW-1:0]       wr_idx;
    logic [ROW_W-1:0]    row_old;
    logic [ROW_W-1:0]    row_new;
    logic [SUPER_SYS_COLS-1:0] clip;
    logic                first_pass;
    logic                misalign;
    logic                last_row;
    logic                last_tile;
    logic                last_rd;

    always_comb begin
        first_pass = (tile_cnt_q == 8'd0);
        misalign   = in_valid && in_accum_start && (wr_ptr_q != '0);
        last_row   = (wr_ptr_q == rows_q - RW'(1));
        last_tile  = (tile_cnt_q == tiles_q - 8'd1);
        last_rd    = (rd_ptr_q == rows_q - RW'(1));
        row_old    = mem_q[wr_idx];
    end

    for (genvar i = 0; i < SUPER_SYS_COLS; i++) begin : g_lane
        gemm_accum_buf_acc_lane #(
            .P_BITWIDTH(P_BITWIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_lane (
            .psum     (in_data[i*P_BITWIDTH +: P_BITWIDTH]),
            .acc_old  (row_old[i*ACC_WIDTH +: ACC_WIDTH]),
            .overwrite(first_pass),
            .acc_new  (row_new[i*ACC_WIDTH +: ACC_WIDTH]),
            .clip     (clip[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rows_d     = rows_q;
        tiles_d    = tiles_q;
        tile_cnt_d = tile_cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = wr_ptr_q[PW-1:0];

        case (state_q)
            ACC_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (cfg_rows != '0 && cfg_tiles != 8'd0) begin
                        rows_d     = cfg_rows;
                        tiles_d    = cfg_tiles;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        tile_cnt_d = 8'd0;
                        state_d    = ACC_ACCUM;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                if (in_valid) begin
                    err_d = 1'b1;
                end
            end
            ACC_ACCUM: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    // A pass restarting mid-row is resynchronised onto row 0 without counting a tile.
                    if (misalign) begin
                        err_d    = 1'b1;
                        wr_idx   = '0;
                        wr_ptr_d = RW'(1);
                    end else if (last_row) begin
                        wr_ptr_d = '0;
                        if (last_tile) begin
                            tile_cnt_d = 8'd0;
                            state_d    = ACC_DRAIN;
                        end else begin
                            tile_cnt_d = tile_cnt_q + 8'd1;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + RW'(1);
                    end
                    if (|clip) begin
                        err_d = 1'b1;
                    end
                end
            end
            ACC_DRAIN: begin
                if (in_valid) begin
                    err_d = 1'b1;
                end
                if (out_ready) begin
                    if (last_rd) begin
                        rd_ptr_d = '0;
                        done_d   = 1'b1;
                        state_d  = ACC_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + RW'(1);
                    end
                end
            end
            default: state_d = ACC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACC_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rows_q     <= '0;
            tiles_q    <= 8'd0;
            tile_cnt_q <= 8'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rows_q     <= rows_d;
            tiles_q    <= tiles_d;
            tile_cnt_q <= tile_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_idx] <= row_new;
        end
    end

    // Output handshake: a row transfers on any edge where out_valid && out_ready. out_valid
    // is held from DRAIN entry until the last transfer and out_data only moves after a transfer.
    always_comb begin
        out_valid = (state_q == ACC_DRAIN);
        out_data  = mem_q[rd_ptr_q[PW-1:0]];
        busy      = (state_q != ACC_IDLE);
        done      = done_q;
        err       = err_q;
    end

endmodule
